// File: rtl/game_state_sequencer.sv
// Per-frame pong game logic: on each vsync falling edge, move pads and ball, resolve
// bounces, pad hits and scoring, then commit every visible position in a single cycle.
module game_state_sequencer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PAD_HEIGHT    = 64,
    parameter int PAD_WIDTH     = 8,
    parameter int PAD_DISTANCE  = 16,
    parameter int BALL_SIZE     = 8,
    parameter int PAD_SPEED     = 4,
    parameter int BALL_SPEED    = 2
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       vga_vs,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic       serve,
    output logic [8:0] pad_left,
    output logic [8:0] pad_right,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       busy,
    output logic       frame_done,
    output logic       missed_frame
);
    typedef logic signed [10:0] s11_t;
    typedef enum logic [2:0] {IDLE, PADS, BALL_Y, BALL_X, SCORE, COMMIT} state_t;

    localparam s11_t PAD_MIN = s11_t'(PAD_HEIGHT / 2);
    localparam s11_t PAD_MAX = s11_t'(SCREEN_HEIGHT - PAD_HEIGHT / 2);
    localparam s11_t PSPD    = s11_t'(PAD_SPEED);
    localparam s11_t BSPD    = s11_t'(BALL_SPEED);
    localparam s11_t HB      = s11_t'(BALL_SIZE / 2);
    localparam s11_t LF      = s11_t'(PAD_DISTANCE + PAD_WIDTH);
    localparam s11_t RF      = s11_t'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH);
    localparam s11_t REACH   = s11_t'(PAD_HEIGHT / 2 + BALL_SIZE / 2);
    localparam s11_t Y_TOP   = s11_t'(BALL_SIZE / 2);
    localparam s11_t Y_BOT   = s11_t'(SCREEN_HEIGHT - BALL_SIZE / 2);
    localparam s11_t X_LEFT  = s11_t'(BALL_SIZE / 2);
    localparam s11_t X_RIGHT = s11_t'(SCREEN_WIDTH - BALL_SIZE / 2);
    localparam s11_t X_MID   = s11_t'(SCREEN_WIDTH / 2);
    localparam s11_t Y_MID   = s11_t'(SCREEN_HEIGHT / 2);

    state_t     state;
    logic       vs_q, tick;
    logic [4:0] sync_a, sync_b;   // {serve, r_dn, r_up, l_dn, l_up}
    s11_t       wl, wr, wx, wy;
    logic       dx, dy, active, point_l, point_r;

    s11_t nl, nr, ny, nx, dl, dr;
    logic hit_l, hit_r;

    function automatic s11_t move_pad(input s11_t y, input logic up, input logic dn);
        s11_t n;
        n = y;
        if (up && !dn) n = y - PSPD;
        else if (dn && !up) n = y + PSPD;
        if (n < PAD_MIN) n = PAD_MIN;
        else if (n > PAD_MAX) n = PAD_MAX;
        return n;
    endfunction

    assign tick = vs_q & ~vga_vs;

    always_comb begin
        nl = move_pad(wl, sync_b[0], sync_b[1]);
        nr = move_pad(wr, sync_b[2], sync_b[3]);
        ny = wy + (dy ? BSPD : -BSPD);
        nx = wx + (dx ? BSPD : -BSPD);
        dl = wy - wl;
        if (dl < 0) dl = -dl;
        dr = wy - wr;
        if (dr < 0) dr = -dr;
        // The old-position test stops a ball that already slipped past a face from re-hitting.
        hit_l = !dx && (nx - HB <= LF) && (wx - HB > LF - BSPD) && (dl < REACH);
        hit_r = dx && (nx + HB >= RF) && (wx + HB < RF + BSPD) && (dr < REACH);
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state        <= IDLE;
            vs_q         <= 1'b0;
            sync_a       <= '0;
            sync_b       <= '0;
            wl           <= Y_MID;
            wr           <= Y_MID;
            wx           <= X_MID;
            wy           <= Y_MID;
            dx           <= 1'b1;
            dy           <= 1'b1;
            active       <= 1'b0;
            point_l      <= 1'b0;
            point_r      <= 1'b0;
            pad_left     <= Y_MID[8:0];
            pad_right    <= Y_MID[8:0];
            ball_x       <= X_MID[9:0];
            ball_y       <= Y_MID[8:0];
            score_left   <= '0;
            score_right  <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            missed_frame <= 1'b0;
        end else begin
            vs_q         <= vga_vs;
            sync_a       <= {serve, btn_r_dn, btn_r_up, btn_l_dn, btn_l_up};
            sync_b       <= sync_a;
            frame_done   <= 1'b0;
            missed_frame <= tick && (state != IDLE);
            case (state)
                IDLE: if (tick) begin
                    wl      <= s11_t'({2'b00, pad_left});
                    wr      <= s11_t'({2'b00, pad_right});
                    wx      <= s11_t'({1'b0, ball_x});
                    wy      <= s11_t'({2'b00, ball_y});
                    point_l <= 1'b0;
                    point_r <= 1'b0;
                    busy    <= 1'b1;
                    state   <= PADS;
                end
                PADS: begin
                    wl <= nl;
                    wr <= nr;
                    if (!active && sync_b[4]) active <= 1'b1;
                    state <= BALL_Y;
                end
                BALL_Y: begin
                    if (active) begin
                        if (ny <= Y_TOP) begin
                            wy <= Y_TOP;
                            dy <= 1'b1;
                        end else if (ny >= Y_BOT) begin
                            wy <= Y_BOT;
                            dy <= 1'b0;
                        end else begin
                            wy <= ny;
                        end
                    end
                    state <= BALL_X;
                end
                BALL_X: begin
                    if (active) begin
                        if (hit_l) begin
                            wx <= LF + HB;
                            dx <= 1'b1;
                        end else if (hit_r) begin
                            wx <= RF - HB;
                            dx <= 1'b0;
                        end else begin
                            wx      <= nx;
                            point_r <= (nx <= X_LEFT);
                            point_l <= (nx >= X_RIGHT);
                        end
                    end
                    state <= SCORE;
                end
                SCORE: begin
                    // The serve after a point heads toward the player who conceded it.
                    if (point_l || point_r) begin
                        wx     <= X_MID;
                        wy     <= Y_MID;
                        active <= 1'b0;
                        dx     <= point_l;
                    end
                    if (point_l && score_left != 4'd9) score_left <= score_left + 4'd1;
                    if (point_r && score_right != 4'd9) score_right <= score_right + 4'd1;
                    state <= COMMIT;
                end
                COMMIT: begin
                    pad_left   <= wl[8:0];
                    pad_right  <= wr[8:0];
                    ball_x     <= wx[9:0];
                    ball_y     <= wy[8:0];
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
